// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache.
// State encoding, geometry checks and the byte-enable word merge.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } cache_state_t;

   localparam int MAX_DW = 256;

   function automatic int tag_width(input int aw, input int sw);
      return aw - sw - 2;
   endfunction

   function automatic bit ways_legal(input int w);
      return (w == 1) || (w == 2) || (w == 4);
   endfunction

   // Callers widen to MAX_DW and truncate the result back.
   function automatic logic [MAX_DW-1:0] merge_word(
      input logic [MAX_DW-1:0]   old_w,
      input logic [MAX_DW-1:0]   new_w,
      input logic [MAX_DW/8-1:0] be
   );
      logic [MAX_DW-1:0] r;
      r = old_w;
      for (int i = 0; i < MAX_DW/8; i++) begin
         if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty/tag/data per set, tag compare,
// byte-enabled store port and full-word refill port.
module cache_way
   import cache_pkg::*;
#(
   parameter int SET_WIDTH  = 3,
   parameter int TAG_WIDTH  = 27,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SET_WIDTH-1:0]    i_set,
   input  logic [TAG_WIDTH-1:0]    i_tag,
   input  logic                    i_st_en,
   input  logic [DATA_WIDTH/8-1:0] i_st_be,
   input  logic [DATA_WIDTH-1:0]   i_st_data,
   input  logic                    i_fill_en,
   input  logic [DATA_WIDTH-1:0]   i_fill_data,
   output logic                    o_valid,
   output logic                    o_dirty,
   output logic                    o_hit,
   output logic [TAG_WIDTH-1:0]    o_tag,
   output logic [DATA_WIDTH-1:0]   o_data
);

   localparam int NSETS = 1 << SET_WIDTH;

   logic [NSETS-1:0]      r_valid;
   logic [NSETS-1:0]      r_dirty;
   logic [TAG_WIDTH-1:0]  r_tag  [NSETS];
   logic [DATA_WIDTH-1:0] r_data [NSETS];
   logic [DATA_WIDTH-1:0] w_merged;

   assign o_valid = r_valid[i_set];
   assign o_dirty = r_dirty[i_set];
   assign o_tag   = r_tag[i_set];
   assign o_data  = r_data[i_set];
   assign o_hit   = o_valid && (o_tag == i_tag);

   assign w_merged = DATA_WIDTH'(merge_word(
      MAX_DW'(r_data[i_set]),
      MAX_DW'(i_st_data),
      (MAX_DW/8)'(i_st_be)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_en) begin
         r_valid[i_set] <= 1'b1;
         r_dirty[i_set] <= 1'b0;
      end else if (i_st_en) begin
         r_dirty[i_set] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid qualifies them.
   always_ff @(posedge clk) begin
      if (i_fill_en) begin
         r_tag[i_set]  <= i_tag;
         r_data[i_set] <= i_fill_data;
      end else if (i_st_en) begin
         r_data[i_set] <= w_merged;
      end
   end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way write-back, write-allocate data cache, one-word lines.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SET_WIDTH  = 3,
   parameter int WAYS       = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_be,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    cpu_ready,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
`endif
);

   localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, SET_WIDTH);
   localparam int NSETS     = 1 << SET_WIDTH;
   localparam int PW        = (WAYS > 1) ? $clog2(WAYS) : 1;

   if (!ways_legal(WAYS)) begin : g_bad_ways
      $error("set_assoc_cache: WAYS must be 1, 2 or 4");
   end

   cache_state_t r_state, w_next;

   logic [SET_WIDTH-1:0]  w_set;
   logic [TAG_WIDTH-1:0]  w_tag;
   logic                  w_unused_ofs;
   logic [WAYS-1:0]       w_valid, w_dirty, w_hitv;
   logic [WAYS-1:0]       w_st_en, w_fill_en;
   logic [TAG_WIDTH-1:0]  w_way_tag  [WAYS];
   logic [DATA_WIDTH-1:0] w_way_data [WAYS];
   logic [PW-1:0]         r_ptr [NSETS];
   logic [PW-1:0]         r_vic, w_vic, w_sel;
   logic                  r_vic_ptr, w_vic_ptr;
   logic                  w_idle, w_hit, w_miss, w_fill;
   logic                  w_sel_valid, w_sel_dirty;
   logic [TAG_WIDTH-1:0]  w_sel_tag;
   logic [DATA_WIDTH-1:0] w_sel_data, w_hit_data;

   assign w_set        = cpu_addr[SET_WIDTH+1:2];
   assign w_tag        = cpu_addr[ADDR_WIDTH-1:SET_WIDTH+2];
   assign w_unused_ofs = ^cpu_addr[1:0];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign w_st_en[g]   = w_idle && cpu_req && cpu_we && w_hitv[g];
      assign w_fill_en[g] = w_fill && (r_vic == PW'(g));

      cache_way #(
         .SET_WIDTH  (SET_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_way (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_set       (w_set),
         .i_tag       (w_tag),
         .i_st_en     (w_st_en[g]),
         .i_st_be     (cpu_be),
         .i_st_data   (cpu_wdata),
         .i_fill_en   (w_fill_en[g]),
         .i_fill_data (mem_rdata),
         .o_valid     (w_valid[g]),
         .o_dirty     (w_dirty[g]),
         .o_hit       (w_hitv[g]),
         .o_tag       (w_way_tag[g]),
         .o_data      (w_way_data[g])
      );
   end

   assign w_idle = (r_state == IDLE);
   assign w_hit  = |w_hitv;
   assign w_miss = w_idle && cpu_req && !w_hit;
   assign w_fill = (r_state == REFILL) && mem_ack;

   // Lowest invalid way wins; otherwise the set's round-robin pointer.
   always_comb begin
      w_vic     = r_ptr[w_set];
      w_vic_ptr = 1'b1;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!w_valid[i]) begin
            w_vic     = PW'(i);
            w_vic_ptr = 1'b0;
         end
      end
   end

   assign w_sel = w_idle ? w_vic : r_vic;

   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_dirty = 1'b0;
      w_sel_tag   = '0;
      w_sel_data  = '0;
      w_hit_data  = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (w_sel == PW'(i)) begin
            w_sel_valid = w_valid[i];
            w_sel_dirty = w_dirty[i];
            w_sel_tag   = w_way_tag[i];
            w_sel_data  = w_way_data[i];
         end
         if (w_hitv[i]) w_hit_data = w_way_data[i];
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_miss)
               w_next = (w_sel_valid && w_sel_dirty) ? WRITEBACK : REFILL;
         end
         WRITEBACK: if (mem_ack) w_next = REFILL;
         REFILL:    if (mem_ack) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_vic     <= '0;
         r_vic_ptr <= 1'b0;
         r_ptr     <= '{default: '0};
      end else begin
         r_state <= w_next;
         if (w_miss) begin
            r_vic     <= w_vic;
            r_vic_ptr <= w_vic_ptr;
         end
         if (w_fill && r_vic_ptr && (WAYS > 1))
            r_ptr[w_set] <= r_ptr[w_set] + PW'(1);
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (r_state)
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {w_sel_tag, w_set, 2'b00};
            mem_wdata = w_sel_data;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {w_tag, w_set, 2'b00};
         end
         default: ;
      endcase
   end

   assign cpu_ready = rst_n && w_idle && (!cpu_req || w_hit);
   assign cpu_rdata = (w_idle && cpu_req && !cpu_we && w_hit)
                    ? w_hit_data : '0;

`ifdef CACHE_STATS_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;
   logic        r_post_fill;

   // The re-evaluation cycle right after a refill is not a fresh hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_post_fill <= 1'b0;
      end else begin
         r_post_fill <= w_fill;
         if (w_idle && cpu_req && w_hit && !r_post_fill && (r_hit_cnt != '1))
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_miss && (r_miss_cnt != '1))
            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache (WAYS=2, 8 sets).
// Loads and memory transactions are checked by separate monitors.
module tb_set_assoc_cache;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [3:0]  cpu_be = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   always #5 clk = ~clk;

   set_assoc_cache #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .SET_WIDTH  (3),
      .WAYS       (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_be    (cpu_be),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_t;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] exp_rd [$];
   mem_t        exp_mem [$];
   logic [31:0] mem_model [logic [31:0]];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory: acks every request on its second cycle.
   initial begin : responder
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (!rst_n || !mem_req) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt == 2) begin
               cnt = 0;
               mem_ack = 1'b1;
               if (mem_we)
                  mem_model[mem_addr] = mem_wdata;
               else
                  mem_rdata = mem_model.exists(mem_addr)
                            ? mem_model[mem_addr] : 32'h0;
            end
         end
      end
   end

   initial begin : mon_mem
      mem_t m;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req && mem_ack) begin
            if (exp_mem.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL mem_unexpected: got we=%0d addr %h expected none",
                        mem_we, mem_addr);
            end else begin
               m = exp_mem.pop_front();
               chk("mem_we", 32'(mem_we), 32'(m.we));
               chk("mem_addr", mem_addr, m.addr);
               if (m.we) chk("mem_wdata", mem_wdata, m.data);
            end
         end
      end
   end

   initial begin : mon_cpu
      forever begin
         @(negedge clk);
         if (rst_n && cpu_req && !cpu_we && cpu_ready) begin
            if (exp_rd.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL load_unexpected: got %h expected none", cpu_rdata);
            end else begin
               chk("load_rdata", cpu_rdata, exp_rd.pop_front());
            end
         end
      end
   end

   task automatic access(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input int exp_stall,
                         input string name);
      int stalls;
      bit done;
      stalls = 0;
      done = 1'b0;
      @(posedge clk);
      #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      cpu_be    = be;
      if (!we) exp_rd.push_back(exp_rdata);
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (cpu_ready) done = 1'b1;
         else stalls++;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: got no cpu_ready expected ready", name);
      end
      chk({name, "_stall"}, 32'(stalls), 32'(exp_stall));
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

   initial begin : stim
      bit seen;
      mem_model[32'h40] = 32'hDEAD_BEEF;
      mem_model[32'h60] = 32'h6060_6060;
      mem_model[32'h80] = 32'h8080_8080;
      mem_model[32'hA0] = 32'h1111_1111;

      #12;
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(cpu_ready), 32'd1);

      exp_mem.push_back('{1'b0, 32'h40, 32'h0});
      access(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 3, "t1_miss");
      access(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, "t1_hit");
`ifdef CACHE_STATS_EN
      chk("hit_count", hit_count, 32'd1);
      chk("miss_count", miss_count, 32'd1);
      @(posedge clk);
      #1;
      force dut.r_hit_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_hit_cnt;
      access(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, "t6_hit");
      chk("hit_count_sat", hit_count, 32'hFFFF_FFFF);
`endif

      access(1'b1, 32'h40, 32'h1234_5678, 4'b0011, 32'h0, 0, "t2_st");
      access(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_5678, 0, "t2_ld");

      exp_mem.push_back('{1'b0, 32'h60, 32'h0});
      access(1'b0, 32'h60, 32'h0, 4'h0, 32'h6060_6060, 3, "t3_way1");
      exp_mem.push_back('{1'b1, 32'h40, 32'hDEAD_5678});
      exp_mem.push_back('{1'b0, 32'h80, 32'h0});
      access(1'b0, 32'h80, 32'h0, 4'h0, 32'h8080_8080, 5, "t3_evict");

      exp_mem.push_back('{1'b0, 32'hA0, 32'h0});
      access(1'b1, 32'hA0, 32'h0000_00FF, 4'b0001, 32'h0, 3, "t4_stmiss");
      access(1'b0, 32'hA0, 32'h0, 4'h0, 32'h1111_11FF, 0, "t4_ld");
      exp_mem.push_back('{1'b0, 32'h40, 32'h0});
      access(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_5678, 3, "t4_clean");
      exp_mem.push_back('{1'b1, 32'hA0, 32'h1111_11FF});
      exp_mem.push_back('{1'b0, 32'h60, 32'h0});
      access(1'b0, 32'h60, 32'h0, 4'h0, 32'h6060_6060, 5, "t4_dirty");

      @(posedge clk);
      #1;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h80;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      chk("t5_req_seen", 32'(mem_req), 32'd1);
      chk("t5_refill_addr", mem_addr, 32'h80);
      chk("t5_refill_we", 32'(mem_we), 32'd0);
      #2;
      rst_n   = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("t5_req_drop", 32'(mem_req), 32'd0);
      chk("t5_ready_low", 32'(cpu_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_mem.push_back('{1'b0, 32'h40, 32'h0});
      access(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_5678, 3, "t5_after_rst");

      repeat (3) @(negedge clk);
      chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
      chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
